pwm_deadtime_monitor: RTL and testbench
=======================================

# pwm_deadtime_monitor

Receive-side checker for complementary bipolar PWM gate pairs. It synchronises the P and N gate signals and measures, per PWM period, the P on-time, N on-time, both dead-time gaps and the period length, all in clock cycles. It flags shoot-through (P and N high together) and dead-time shortfall. It sits on the gate-drive pins next to the bipolar PWM generator, or on loop-back inputs in test builds, and feeds status and measurement registers.

## Interface

Parameters:

- CNT_W, 16: width of every measurement counter and output.
- SYNC_STAGES, 2: flip-flop synchroniser depth per input, minimum 2.

Ports:

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  measurement enable
- pwm_p_in  in  1  positive gate signal, asynchronous to clk
- pwm_n_in  in  1  negative gate signal, asynchronous to clk
- min_dead_cycles  in  8  required minimum dead-time; 0 disables the check
- clear_flags  in  1  single-cycle clear for the sticky flags
- period_cycles  out  CNT_W  last measured period
- p_high_cycles  out  CNT_W  last P on-time
- n_high_cycles  out  CNT_W  last N on-time
- dead_pn_cycles  out  CNT_W  last P-fall to N-rise gap
- dead_np_cycles  out  CNT_W  last N-fall to P-rise gap
- meas_valid  out  1  one-cycle pulse when the measurement outputs update
- shoot_through  out  1  sticky flag: P and N both high
- dead_violation  out  1  sticky flag: a published gap was below min_dead_cycles
- timeout  out  1  sticky flag: period counter saturated

## Operation

Input conditioning:

- Each input passes through SYNC_STAGES flops to give the synchronised pair s = {p_s, n_s}.
- All logic below acts on s.

FSM states and transitions:

- HUNT: wait until s==10 with the previous s != 10. Then go to P_ON with period=1, p_high=1, and all other counters=0.
- P_ON:
  - s==10: p_high++.
  - s==00: go to DEAD_PN, dead_pn=1.
  - s==01: go to N_ON, dead_pn=0, n_high=1.
- DEAD_PN:
  - s==00: dead_pn++.
  - s==01: go to N_ON, n_high=1.
  - s==10 (missing N pulse): go to P_ON and restart the counters as in HUNT. No publish.
- N_ON:
  - s==01: n_high++.
  - s==00: go to DEAD_NP, dead_np=1.
  - s==10: publish with dead_np=0, then go to P_ON with restarted counters.
- DEAD_NP:
  - s==00: dead_np++.
  - s==10: publish, then go to P_ON with restarted counters.
  - s==01 (N glitch): go to HUNT, no publish.

Overrides and period counting:

- In any state, s==11 sets shoot_through, sends the FSM to HUNT and clears the counters. The FSM stays in HUNT while s==11.
- The period counter increments every cycle outside HUNT.

Published values:

- Invariant: period = p_high + dead_pn + n_high + dead_np.
- The P-rise sample that triggers a publish is counted in the new period, not the old one.
- Publish loads all five outputs and pulses meas_valid for one cycle.
- dead_violation is set on publish if min_dead_cycles != 0 and either published gap is below min_dead_cycles.

Saturation and timeout:

- All counters saturate at 2^CNT_W-1.
- When the period counter reaches saturation: set timeout, go to HUNT, no publish.

enable and clear_flags:

- enable low: the FSM is forced to HUNT and the counters are cleared. Measurement outputs and flags hold their values.
- clear_flags clears all three sticky flags. If a set event occurs in the same cycle, set wins.

## Timing

- Reset (asynchronous, reset_n=0): all outputs 0, FSM in HUNT, synchroniser flops 0, counters 0.
- Latency: a pin transition sampled at clk edge k appears in s after edge k+SYNC_STAGES-1. The FSM acts on it at edge k+SYNC_STAGES.
  - meas_valid and flag updates are therefore registered at edge k+SYNC_STAGES and are high for the cycle that follows.
- The first publish needs one complete P→N→P sequence after HUNT. There is no publish on the first P rise.
- reset_n asserted mid-period abandons the measurement. After release the FSM waits in HUNT.
- Publish and flag set happen in the same cycle when the closing period has a violation.
- Input pulses shorter than one clk period may be missed. This is not flagged.

## Test plan

- Clean waveform, SYNC_STAGES=2, min_dead_cycles=3. Repeat P high 10, 00 for 3, N high 12, 00 for 3 → from the second P rise: meas_valid every 28 cycles with period=28, p_high=10, n_high=12, dead_pn=3, dead_np=3, flags 0. First meas_valid comes 2 cycles after the sampled pin edge.
- Same waveform with the N→P gap cut to 1 → dead_np=1, dead_violation=1 and latched. clear_flags with no violation in that cycle → 0. clear_flags in the same cycle as the next violating publish → stays 1.
- Force P and N high for 2 cycles mid-N_ON → shoot_through=1, no meas_valid for that period. The next complete clean period publishes correct values.
- Direct 10→01→10 switching, 20/20 cycles, min_dead_cycles=0 → period=40, both dead=0, dead_violation=0. Same waveform with min_dead_cycles=1 → dead_violation=1.
- Hold P high with CNT_W=8 → timeout=1 at 255 cycles, no meas_valid. Normal pulses afterwards → measurement resumes after one full period.
- Assert reset_n low during DEAD_PN → all outputs 0 immediately, asynchronously. After release the first meas_valid comes only after a full P→P sequence. enable low mid-period → no publish and outputs held.

Source files
------------

// File: rtl/pwm_deadtime_monitor.sv
// Receive-side checker for a complementary P/N gate pair: measures on-times, dead-time
// gaps and period per PWM cycle, and flags shoot-through, dead-time shortfall and timeout.
module pwm_deadtime_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_p_in,
  input  logic             pwm_n_in,
  input  logic [7:0]       min_dead_cycles,
  input  logic             clear_flags,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] p_high_cycles,
  output logic [CNT_W-1:0] n_high_cycles,
  output logic [CNT_W-1:0] dead_pn_cycles,
  output logic [CNT_W-1:0] dead_np_cycles,
  output logic             meas_valid,
  output logic             shoot_through,
  output logic             dead_violation,
  output logic             timeout
);

  localparam int              EW     = CNT_W + 8;
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CMAX   = '1;
  localparam logic [CNT_W-1:0] SAT_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [1:0]       S_P    = 2'b10;
  localparam logic [1:0]       S_N    = 2'b01;
  localparam logic [1:0]       S_Z    = 2'b00;

  typedef enum logic [2:0] {HUNT, P_ON, DEAD_PN, N_ON, DEAD_NP} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] ph;
    logic [CNT_W-1:0] dpn;
    logic [CNT_W-1:0] nh;
    logic [CNT_W-1:0] dnp;
  } cnt_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // A P rise opens a new period and is its first counted sample.
  function automatic cnt_t restart();
    cnt_t c;
    c     = '0;
    c.per = ONE;
    c.ph  = ONE;
    return c;
  endfunction

  logic [1:0]                  pins;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  s, prev_s;
  state_t                      state, state_d;
  cnt_t                        cnt, cnt_d;
  logic                        publish, st_set, to_set, viol;

  assign pins = {pwm_p_in, pwm_n_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else for (int i = 0; i < 2; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
  end

  assign s = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    publish = 1'b0;
    st_set  = 1'b0;
    to_set  = 1'b0;
    if (!enable) begin
      state_d = HUNT;
      cnt_d   = '0;
    end else if (s == 2'b11) begin
      st_set  = 1'b1;
      state_d = HUNT;
      cnt_d   = '0;
    end else if (state != HUNT && cnt.per == SAT_M1) begin
      // this increment would saturate the period counter
      to_set  = 1'b1;
      state_d = HUNT;
      cnt_d   = '0;
    end else begin
      if (state != HUNT) cnt_d.per = sat_inc(cnt.per);
      case (state)
        HUNT: if (s == S_P && prev_s != S_P) begin
          state_d = P_ON;
          cnt_d   = restart();
        end
        P_ON: case (s)
          S_P: cnt_d.ph = sat_inc(cnt.ph);
          S_Z: begin state_d = DEAD_PN; cnt_d.dpn = ONE; end
          S_N: begin state_d = N_ON; cnt_d.dpn = '0; cnt_d.nh = ONE; end
          default: ;
        endcase
        DEAD_PN: case (s)
          S_Z: cnt_d.dpn = sat_inc(cnt.dpn);
          S_N: begin state_d = N_ON; cnt_d.nh = ONE; end
          S_P: begin state_d = P_ON; cnt_d = restart(); end
          default: ;
        endcase
        N_ON: case (s)
          S_N: cnt_d.nh = sat_inc(cnt.nh);
          S_Z: begin state_d = DEAD_NP; cnt_d.dnp = ONE; end
          S_P: begin publish = 1'b1; state_d = P_ON; cnt_d = restart(); end
          default: ;
        endcase
        DEAD_NP: case (s)
          S_Z: cnt_d.dnp = sat_inc(cnt.dnp);
          S_P: begin publish = 1'b1; state_d = P_ON; cnt_d = restart(); end
          S_N: begin state_d = HUNT; cnt_d = '0; end
          default: ;
        endcase
        default: begin state_d = HUNT; cnt_d = '0; end
      endcase
    end
  end

  assign viol = publish && (min_dead_cycles != 8'd0) &&
                ((EW'(cnt.dpn) < EW'(min_dead_cycles)) || (EW'(cnt.dnp) < EW'(min_dead_cycles)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= HUNT;
      cnt            <= '0;
      prev_s         <= '0;
      period_cycles  <= '0;
      p_high_cycles  <= '0;
      n_high_cycles  <= '0;
      dead_pn_cycles <= '0;
      dead_np_cycles <= '0;
      meas_valid     <= 1'b0;
      shoot_through  <= 1'b0;
      dead_violation <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      prev_s     <= s;
      meas_valid <= publish;
      if (publish) begin
        period_cycles  <= cnt.per;
        p_high_cycles  <= cnt.ph;
        n_high_cycles  <= cnt.nh;
        dead_pn_cycles <= cnt.dpn;
        dead_np_cycles <= cnt.dnp;
      end
      // set beats a same-cycle clear
      shoot_through  <= st_set | (shoot_through  & ~clear_flags);
      dead_violation <= viol   | (dead_violation & ~clear_flags);
      timeout        <= to_set | (timeout        & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_monitor.sv
// Bench for pwm_deadtime_monitor: table-driven waveform rows feeding a publish scoreboard,
// plus scripted shoot-through, timeout, reset and enable sequences.
module tb_pwm_deadtime_monitor;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0, enable = 1'b0, pwm_p_in = 1'b0, pwm_n_in = 1'b0;
  logic          clear_flags = 1'b0;
  logic [7:0]    min_dead = 8'd0;
  logic [CW-1:0] period_cycles, p_high_cycles, n_high_cycles, dead_pn_cycles, dead_np_cycles;
  logic          meas_valid, shoot_through, dead_violation, timeout;

  pwm_deadtime_monitor #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pwm_p_in(pwm_p_in), .pwm_n_in(pwm_n_in),
    .min_dead_cycles(min_dead), .clear_flags(clear_flags),
    .period_cycles(period_cycles), .p_high_cycles(p_high_cycles),
    .n_high_cycles(n_high_cycles), .dead_pn_cycles(dead_pn_cycles),
    .dead_np_cycles(dead_np_cycles), .meas_valid(meas_valid),
    .shoot_through(shoot_through), .dead_violation(dead_violation), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int per; int ph; int nh; int dpn; int dnp; bit dv; bit st; bit to;} exp_t;
  typedef struct {int ph; int dpn; int nh; int dnp; int mind; int reps; int per; bit dv; bit clr;} row_t;

  exp_t sbq[$];
  row_t rows[4];
  int   n_cmp = 0, n_bad = 0;
  bit   clr_at_pub = 1'b0;
  bit   exp_st = 1'b0, exp_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int per, ph, nh, dpn, dnp, input bit dv);
    exp_t e;
    e.per = per; e.ph = ph; e.nh = nh; e.dpn = dpn; e.dnp = dnp;
    e.dv = dv; e.st = exp_st; e.to = exp_to;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_meas_valid: got 1, want 0 (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          chk("period",         32'(period_cycles),  e.per);
          chk("p_high",         32'(p_high_cycles),  e.ph);
          chk("n_high",         32'(n_high_cycles),  e.nh);
          chk("dead_pn",        32'(dead_pn_cycles), e.dpn);
          chk("dead_np",        32'(dead_np_cycles), e.dnp);
          chk("dead_violation", 32'(dead_violation), 32'(e.dv));
          chk("shoot_through",  32'(shoot_through),  32'(e.st));
          chk("timeout",        32'(timeout),        32'(e.to));
        end
      end
    end
  end

  task automatic seg(input bit p, input bit n, input int len);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      pwm_p_in = p; pwm_n_in = n;
    end
  endtask

  // P-high segment; when pub is set its rise closes a period and e is expected.
  task automatic p_high(input int len, input bit pub, input exp_t e);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (pub && j == 0) sbq.push_back(e);
      if (pub && j == 2) begin
        chk("lat_early", 32'(meas_valid), 0);
        if (clr_at_pub) clear_flags = 1'b1;
      end
      if (pub && j == 3) begin
        chk("lat_pulse", 32'(meas_valid), 1);
        clear_flags = 1'b0;
      end
      pwm_p_in = 1'b1; pwm_n_in = 1'b0;
    end
  endtask

  task automatic drive_period(input int ph, dpn, nh, dnp, input bit pub, input exp_t e);
    p_high(ph, pub, e);
    seg(1'b0, 1'b0, dpn);
    seg(1'b0, 1'b1, nh);
    seg(1'b0, 1'b0, dnp);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear_flags = 1'b1;
    @(negedge clk) clear_flags = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    exp_t e;
    rows[0] = '{10, 3, 12, 3, 3, 3, 28, 1'b0, 1'b0};
    rows[1] = '{10, 3, 12, 1, 3, 2, 26, 1'b1, 1'b0};
    rows[2] = '{20, 0, 20, 0, 0, 2, 40, 1'b0, 1'b0};
    rows[3] = '{20, 0, 20, 0, 1, 2, 40, 1'b1, 1'b1};
    e = mk(0, 0, 0, 0, 0, 1'b0);

    #13;
    chk("rst_period",  32'(period_cycles),  0);
    chk("rst_p_high",  32'(p_high_cycles),  0);
    chk("rst_valid",   32'(meas_valid),     0);
    chk("rst_flags",   32'({shoot_through, dead_violation, timeout}), 0);
    @(negedge clk);
    reset_n = 1'b1; enable = 1'b1;

    for (int r = 0; r < 4; r++) begin
      min_dead   = 8'(rows[r].mind);
      clr_at_pub = rows[r].clr;
      e = mk(rows[r].per, rows[r].ph, rows[r].nh, rows[r].dpn, rows[r].dnp, rows[r].dv);
      for (int i = 0; i < rows[r].reps; i++)
        drive_period(rows[r].ph, rows[r].dpn, rows[r].nh, rows[r].dnp, i > 0, e);
      p_high(6, 1'b1, e);
      seg(1'b0, 1'b0, 4);
      clr_at_pub = 1'b0;
      enable = 1'b0;
      seg(1'b0, 1'b0, 2);
      enable = 1'b1;
      chk("row_dv_after", 32'(dead_violation), 32'(rows[r].dv));
      if (rows[r].dv) begin
        pulse_clear();
        chk("dv_cleared", 32'(dead_violation), 0);
      end
    end

    // shoot-through in the middle of N_ON; the next clean period still publishes
    min_dead = 8'd3;
    p_high(10, 1'b0, e);
    seg(1'b0, 1'b0, 3); seg(1'b0, 1'b1, 6); seg(1'b1, 1'b1, 2);
    seg(1'b0, 1'b1, 5); seg(1'b0, 1'b0, 3);
    chk("shoot_set", 32'(shoot_through), 1);
    exp_st = 1'b1;
    drive_period(10, 3, 12, 3, 1'b0, e);
    e = mk(28, 10, 12, 3, 3, 1'b0);
    p_high(6, 1'b1, e);
    seg(1'b0, 1'b0, 4);

    // P held high: period counter saturates at 255
    for (int j = 0; j < 270; j++) begin
      @(negedge clk);
      if (j == 250) chk("timeout_early", 32'(timeout), 0);
      if (j == 265) chk("timeout_set",   32'(timeout), 1);
      pwm_p_in = 1'b1; pwm_n_in = 1'b0;
    end
    exp_to = 1'b1;
    seg(1'b0, 1'b0, 3);
    e = mk(28, 10, 12, 3, 3, 1'b0);
    drive_period(10, 3, 12, 3, 1'b0, e);
    drive_period(10, 3, 12, 3, 1'b1, e);
    p_high(6, 1'b1, e);
    seg(1'b0, 1'b0, 4);

    // asynchronous reset inside DEAD_PN
    p_high(10, 1'b0, e);
    seg(1'b0, 1'b0, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_period",  32'(period_cycles),  0);
    chk("arst_n_high",  32'(n_high_cycles),  0);
    chk("arst_dead_np", 32'(dead_np_cycles), 0);
    chk("arst_flags",   32'({shoot_through, dead_violation, timeout}), 0);
    exp_st = 1'b0; exp_to = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    seg(1'b0, 1'b0, 1); seg(1'b0, 1'b1, 12); seg(1'b0, 1'b0, 3);
    drive_period(10, 3, 12, 3, 1'b0, e);
    e = mk(28, 10, 12, 3, 3, 1'b0);
    p_high(6, 1'b1, e);
    seg(1'b0, 1'b0, 4);

    // enable dropped mid-period: nothing published, outputs hold
    p_high(10, 1'b0, e);
    seg(1'b0, 1'b0, 3); seg(1'b0, 1'b1, 5);
    enable = 1'b0;
    seg(1'b0, 1'b1, 7); seg(1'b0, 1'b0, 3);
    p_high(6, 1'b0, e);
    seg(1'b0, 1'b0, 3);
    chk("hold_period", 32'(period_cycles), 28);
    chk("hold_p_high", 32'(p_high_cycles), 10);
    chk("hold_valid",  32'(meas_valid),    0);
    enable = 1'b1;

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
